// File: rtl/quad_tdc_counter_array.sv
// quad_tdc_counter_array
// Multi-channel gated quad-tick counter. Each channel measures one enable
// window at a time. Finished results leave through one shared valid/ready
// read port that serves channels in round-robin order.
module quad_tdc_counter_array #(
    parameter int BIT_COUNT = 32,
    parameter int CHANNELS  = 4,
    parameter int QUAD_DIV  = 4
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic [CHANNELS-1:0]                                enable,
    output logic [CHANNELS-1:0]                                has_value,
    output logic [CHANNELS-1:0]                                busy,
    output logic                                               rd_valid,
    input  logic                                               rd_ready,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] rd_channel,
    output logic [BIT_COUNT-1:0]                               rd_count,
    output logic                                               rd_overflow,
    output logic                                               rd_missed
);

    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PRE_W = $clog2(QUAD_DIV);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [CHANNELS-1:0]  r_sync1;
    logic [CHANNELS-1:0]  r_sync2;
    logic [CHANNELS-1:0]  r_enPrev;
    logic [CHANNELS-1:0]  r_armed;
    logic [1:0]           r_settle;

    logic [1:0]           r_state [CHANNELS];
    logic [BIT_COUNT-1:0] r_cnt   [CHANNELS];
    logic [PRE_W-1:0]     r_pre   [CHANNELS];
    logic [CHANNELS-1:0]  r_ovf;
    logic [CHANNELS-1:0]  r_missed;

    logic                 r_rdValid;
    logic [CH_W-1:0]      r_rdChannel;
    logic [BIT_COUNT-1:0] r_rdCount;
    logic                 r_rdOverflow;
    logic                 r_rdMissed;
    logic [CH_W-1:0]      r_rrStart;

    logic                 w_settled;
    logic [CHANNELS-1:0]  w_rise;
    logic [CHANNELS-1:0]  w_fall;
    logic                 w_handshake;
    logic [CHANNELS-1:0]  w_hsMask;
    logic [CHANNELS-1:0]  w_pool;
    logic                 w_grantValid;
    logic [CH_W-1:0]      w_grantIdx;
    int                   w_scanIdx;

    // The settle counter keeps a channel disarmed until its synchroniser has
    // refilled after reset. This way an enable that was already high when
    // reset was released does not look like a new rising edge.
    assign w_settled   = (r_settle == 2'd2);
    assign w_rise      = r_sync2 & ~r_enPrev & r_armed;
    assign w_fall      = ~r_sync2 & r_enPrev;
    assign w_handshake = r_rdValid & rd_ready;

    // Two-flop synchroniser, edge-detect history and post-reset arming.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_enPrev <= '0;
            r_armed  <= '0;
            r_settle <= '0;
        end else begin
            r_sync1  <= enable;
            r_sync2  <= r_sync1;
            r_enPrev <= r_sync2;
            if (!w_settled) begin
                r_settle <= r_settle + 2'd1;
            end
            if (w_settled) begin
                r_armed <= r_armed | ~r_sync2;
            end
        end
    end

    // Decode which channel (if any) completes its read handshake this cycle.
    always_comb begin
        w_hsMask = '0;
        if (w_handshake) begin
            w_hsMask[r_rdChannel] = 1'b1;
        end
    end

    // Per-channel window FSM. The count register doubles as the held result,
    // because the FSM does not touch it while the channel is in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf    <= '0;
            r_missed <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_state[i] <= ST_IDLE;
                r_cnt[i]   <= '0;
                r_pre[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                case (r_state[i])
                    ST_IDLE: begin
                        if (w_rise[i]) begin
                            r_state[i]  <= ST_RUN;
                            r_cnt[i]    <= '0;
                            r_pre[i]    <= '0;
                            r_ovf[i]    <= 1'b0;
                            r_missed[i] <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (w_fall[i]) begin
                            r_state[i] <= ST_DONE;
                        end else if (r_pre[i] == PRE_W'(QUAD_DIV - 1)) begin
                            r_pre[i] <= '0;
                            if (&r_cnt[i]) begin
                                r_ovf[i] <= 1'b1;
                            end else begin
                                r_cnt[i] <= r_cnt[i] + BIT_COUNT'(1);
                            end
                        end else begin
                            r_pre[i] <= r_pre[i] + PRE_W'(1);
                        end
                    end
                    ST_DONE: begin
                        if (w_hsMask[i]) begin
                            r_state[i] <= ST_IDLE;
                        end else if (w_rise[i]) begin
                            r_missed[i] <= 1'b1;
                        end
                    end
                    default: begin
                        r_state[i] <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Round-robin pick of the next DONE channel that is not already in the
    // port. The loop scans downward, so the last hit is the one nearest the
    // start pointer.
    always_comb begin
        w_pool       = '0;
        w_grantValid = 1'b0;
        w_grantIdx   = '0;
        w_scanIdx    = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_pool[i] = (r_state[i] == ST_DONE);
        end
        if (r_rdValid) begin
            w_pool[r_rdChannel] = 1'b0;
        end
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            w_scanIdx = int'(r_rrStart) + k;
            if (w_scanIdx >= CHANNELS) begin
                w_scanIdx = w_scanIdx - CHANNELS;
            end
            if (w_pool[w_scanIdx]) begin
                w_grantValid = 1'b1;
                w_grantIdx   = CH_W'(w_scanIdx);
            end
        end
    end

    // Registered read port. It reloads whenever it is empty or being drained.
    // While a result waits unaccepted, a dropped window on that same channel
    // still sets rd_missed, so the consumer learns about the loss when it
    // finally reads the result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdValid    <= 1'b0;
            r_rdChannel  <= '0;
            r_rdCount    <= '0;
            r_rdOverflow <= 1'b0;
            r_rdMissed   <= 1'b0;
            r_rrStart    <= '0;
        end else if (!r_rdValid || rd_ready) begin
            r_rdValid <= w_grantValid;
            if (w_grantValid) begin
                r_rdChannel  <= w_grantIdx;
                r_rdCount    <= r_cnt[w_grantIdx];
                r_rdOverflow <= r_ovf[w_grantIdx];
                r_rdMissed   <= r_missed[w_grantIdx] | w_rise[w_grantIdx];
                r_rrStart    <= (w_grantIdx == CH_W'(CHANNELS - 1)) ? '0
                                                                    : w_grantIdx + CH_W'(1);
            end
        end else if (w_rise[r_rdChannel]) begin
            r_rdMissed <= 1'b1;
        end
    end

    // Status flags are plain decodes of the registered FSM state.
    always_comb begin
        busy      = '0;
        has_value = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            busy[i]      = (r_state[i] == ST_RUN);
            has_value[i] = (r_state[i] == ST_DONE);
        end
    end

    assign rd_valid    = r_rdValid;
    assign rd_channel  = r_rdChannel;
    assign rd_count    = r_rdCount;
    assign rd_overflow = r_rdOverflow;
    assign rd_missed   = r_rdMissed;

endmodule

// File: tb/tb_quad_tdc_counter_array.sv
// Testbench for quad_tdc_counter_array. Two instances share the same stimulus:
// one has full 32-bit counters and one has 4-bit counters that saturate. A
// window-level model predicts each result from the number of clocks that
// enable was high.
module tb_quad_tdc_counter_array;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  enable;
    logic        rd_ready;

    logic [3:0]  hasValueA, busyA;
    logic        rdValidA, rdOverflowA, rdMissedA;
    logic [1:0]  rdChannelA;
    logic [31:0] rdCountA;

    logic [3:0]  hasValueB, busyB;
    logic        rdValidB, rdOverflowB, rdMissedB;
    logic [1:0]  rdChannelB;
    logic [3:0]  rdCountB;

    int          testsRun = 0;
    int          testsFailed = 0;

    int          hiCount [4];
    int          loCount [4];
    int          target  [4];
    int unsigned expRaw  [4];
    bit          pendA [4];
    bit          pendB [4];
    bit          winValid [4];
    bit          expMissed [4];

    always #5 clk = ~clk;

    quad_tdc_counter_array #(.BIT_COUNT(32), .CHANNELS(4), .QUAD_DIV(4)) dutA (
        .clk(clk), .reset(reset), .enable(enable), .has_value(hasValueA), .busy(busyA),
        .rd_valid(rdValidA), .rd_ready(rd_ready), .rd_channel(rdChannelA),
        .rd_count(rdCountA), .rd_overflow(rdOverflowA), .rd_missed(rdMissedA)
    );

    quad_tdc_counter_array #(.BIT_COUNT(4), .CHANNELS(4), .QUAD_DIV(4)) dutB (
        .clk(clk), .reset(reset), .enable(enable), .has_value(hasValueB), .busy(busyB),
        .rd_valid(rdValidB), .rd_ready(rd_ready), .rd_channel(rdChannelB),
        .rd_count(rdCountB), .rd_overflow(rdOverflowB), .rd_missed(rdMissedB)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Advance n clocks. Accepted results are checked at the falling edge, and
    // the per-channel high/low run lengths are counted at the rising edge.
    task automatic applyStimulus(input int n);
        int ch;
        int unsigned sat;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (rdValidA && rd_ready) begin
                ch = int'(rdChannelA);
                checkOutput("A_pending", pendA[ch], 1);
                checkOutput("A_count", rdCountA, expRaw[ch]);
                checkOutput("A_overflow", rdOverflowA, 0);
                checkOutput("A_missed", rdMissedA, expMissed[ch]);
                pendA[ch] = 1'b0;
            end
            if (rdValidB && rd_ready) begin
                ch  = int'(rdChannelB);
                sat = (expRaw[ch] > 15) ? 15 : expRaw[ch];
                checkOutput("B_pending", pendB[ch], 1);
                checkOutput("B_count", rdCountB, sat);
                checkOutput("B_overflow", rdOverflowB, (expRaw[ch] > 15) ? 1 : 0);
                checkOutput("B_missed", rdMissedB, expMissed[ch]);
                pendB[ch] = 1'b0;
            end
            @(posedge clk);
            for (int i = 0; i < 4; i++) begin
                if (enable[i]) begin
                    hiCount[i]++;
                    loCount[i] = 0;
                end else begin
                    loCount[i]++;
                end
            end
            #1;
        end
    endtask

    task automatic openWindow(input int i, input bit valid);
        enable[i]  = 1'b1;
        hiCount[i] = 0;
        winValid[i] = valid;
        if (valid) begin
            expMissed[i] = 1'b0;
        end else if (pendA[i]) begin
            expMissed[i] = 1'b1;
        end
    endtask

    // The count is floor(RUN cycles / 4). RUN cycles are the enable-high
    // clocks minus one: the rising and falling transitions take one cycle each.
    task automatic closeWindow(input int i);
        enable[i] = 1'b0;
        if (winValid[i]) begin
            expRaw[i]   = (hiCount[i] - 1) / 4;
            pendA[i]    = 1'b1;
            pendB[i]    = 1'b1;
            winValid[i] = 1'b0;
        end
    endtask

    task automatic doReset();
        reset    = 1'b1;
        enable   = '0;
        rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pendA[i] = 0; pendB[i] = 0; winValid[i] = 0; expMissed[i] = 0;
            hiCount[i] = 0; loCount[i] = 0; expRaw[i] = 0;
        end
        applyStimulus(2);
        reset = 1'b0;
        applyStimulus(4);
    endtask

    task automatic drainResults();
        bit any;
        rd_ready = 1'b1;
        for (int w = 0; w < 100; w++) begin
            any = 0;
            for (int i = 0; i < 4; i++) any |= pendA[i] | pendB[i];
            if (any) applyStimulus(1);
        end
        for (int i = 0; i < 4; i++) begin
            checkOutput("drain_A", pendA[i], 0);
            checkOutput("drain_B", pendB[i], 0);
        end
    endtask

    initial begin
        // Reset state
        doReset();
        checkOutput("rst_hasValue", hasValueA, 0);
        checkOutput("rst_busy", busyA, 0);
        checkOutput("rst_rdValid", rdValidA, 0);
        checkOutput("rst_rdChannel", rdChannelA, 0);
        checkOutput("rst_rdCount", rdCountA, 0);
        checkOutput("rst_rdFlags", {rdOverflowA, rdMissedA}, 0);
        checkOutput("rst_B", {hasValueB, busyB, rdValidB, rdCountB}, 0);

        // 40 RUN cycles on ch0 give a count of 10; busy appears 3 clocks after the pin edge
        openWindow(0, 1);
        applyStimulus(2);
        checkOutput("t1_busyLate", busyA[0], 0);
        applyStimulus(1);
        checkOutput("t1_busy", busyA[0], 1);
        applyStimulus(38);
        closeWindow(0);
        applyStimulus(5);
        checkOutput("t1_valid", rdValidA, 1);
        checkOutput("t1_channel", rdChannelA, 0);
        checkOutput("t1_count", rdCountA, 10);
        checkOutput("t1_flags", {rdOverflowA, rdMissedA}, 0);
        checkOutput("t1_hasValue", hasValueA, 4'b0001);
        checkOutput("t1_countB", rdCountB, 10);
        rd_ready = 1'b1;
        applyStimulus(1);
        rd_ready = 1'b0;
        applyStimulus(2);
        checkOutput("t1_hasValueClr", hasValueA, 0);
        checkOutput("t1_validClr", rdValidA, 0);

        // Window shorter than one quad tick gives a count of 0, held until read
        openWindow(0, 1);
        applyStimulus(4);
        closeWindow(0);
        applyStimulus(6);
        checkOutput("t2_hasValue", hasValueA[0], 1);
        checkOutput("t2_valid", rdValidA, 1);
        checkOutput("t2_count", rdCountA, 0);
        applyStimulus(5);
        checkOutput("t2_hasValueHeld", hasValueA[0], 1);
        checkOutput("t2_channelHeld", rdChannelA, 0);
        checkOutput("t2_countHeld", rdCountA, 0);
        rd_ready = 1'b1;
        applyStimulus(1);
        rd_ready = 1'b0;
        applyStimulus(2);
        checkOutput("t2_hasValueClr", hasValueA[0], 0);

        // 100 RUN cycles saturate the 4-bit instance
        openWindow(1, 1);
        applyStimulus(101);
        closeWindow(1);
        applyStimulus(6);
        checkOutput("t3_countB", rdCountB, 15);
        checkOutput("t3_ovfB", rdOverflowB, 1);
        checkOutput("t3_countA", rdCountA, 25);
        checkOutput("t3_ovfA", rdOverflowA, 0);
        drainResults();

        // All four windows close together and drain one per clock, 0..3
        doReset();
        openWindow(0, 1);
        applyStimulus(3);
        openWindow(1, 1);
        applyStimulus(2);
        openWindow(2, 1);
        applyStimulus(5);
        openWindow(3, 1);
        applyStimulus(12);
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) closeWindow(i);
        for (int w = 0; w < 10 && !rdValidA; w++) applyStimulus(1);
        for (int k = 0; k < 4; k++) begin
            checkOutput("t4_valid", rdValidA, 1);
            checkOutput("t4_channel", rdChannelA, k);
            applyStimulus(1);
        end
        checkOutput("t4_empty", rdValidA, 0);
        checkOutput("t4_hasValue", hasValueA, 0);
        rd_ready = 1'b0;

        // A window pulsed while the result waits is dropped and flagged as missed
        openWindow(2, 1);
        applyStimulus(13);
        closeWindow(2);
        applyStimulus(6);
        checkOutput("t5_valid", rdValidA, 1);
        checkOutput("t5_channel", rdChannelA, 2);
        checkOutput("t5_count", rdCountA, 3);
        checkOutput("t5_missedBefore", rdMissedA, 0);
        openWindow(2, 0);
        applyStimulus(4);
        checkOutput("t5_noRestart", busyA[2], 0);
        closeWindow(2);
        applyStimulus(6);
        checkOutput("t5_missed", rdMissedA, 1);
        checkOutput("t5_countHeld", rdCountA, 3);
        checkOutput("t5_hasValue", hasValueA[2], 1);
        rd_ready = 1'b1;
        applyStimulus(1);
        rd_ready = 1'b0;
        applyStimulus(2);
        checkOutput("t5_idle", hasValueA[2], 0);
        openWindow(2, 1);
        applyStimulus(9);
        closeWindow(2);
        drainResults();

        // Reset in the middle of a window with enable held high
        doReset();
        openWindow(3, 1);
        applyStimulus(20);
        checkOutput("t6_busyBefore", busyA[3], 1);
        reset = 1'b1;
        applyStimulus(1);
        checkOutput("t6_busy", busyA, 0);
        checkOutput("t6_hasValue", hasValueA, 0);
        checkOutput("t6_valid", rdValidA, 0);
        reset = 1'b0;
        winValid[3] = 1'b0;
        applyStimulus(60);
        checkOutput("t6_noRestart", busyA[3], 0);
        closeWindow(3);
        applyStimulus(10);
        checkOutput("t6_noResultA", {hasValueA, rdValidA}, 0);
        checkOutput("t6_noResultB", {hasValueB, rdValidB}, 0);
        openWindow(3, 1);
        applyStimulus(17);
        closeWindow(3);
        drainResults();

        // Randomised windows and back-pressure on all channels
        doReset();
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (enable[i]) begin
                    if (hiCount[i] >= target[i]) closeWindow(i);
                end else if (loCount[i] >= 2 && !pendA[i] && !pendB[i] &&
                             $urandom_range(0, 7) == 0) begin
                    target[i] = int'($urandom_range(1, 90));
                    openWindow(i, 1);
                end
            end
            rd_ready = ($urandom_range(0, 3) != 0);
            applyStimulus(1);
        end
        for (int i = 0; i < 4; i++) begin
            if (enable[i]) closeWindow(i);
        end
        drainResults();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
